// File: rtl/alu_scan7seg.sv
// Registered 4-op ALU whose WIDTH+1-bit result is scanned onto a 4-digit
// multiplexed 7-segment display. Define ALU_SCAN7SEG_BLANK_EN for leading-zero blanking.
module alu_scan7seg #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic [1:0]       mode,
  input  logic             load,
  output logic [WIDTH:0]   result,
  output logic             flag,
  output logic             valid,
  output logic [6:0]       g_to_a,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [WIDTH:0]  result_q, result_d;
  logic            flag_q, flag_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      digit_q, digit_d;

  logic [WIDTH:0]  sum_ext, diff_ext, alu_res;
  logic            alu_flag;
  logic            wrap;

  // ALU: the borrow of the WIDTH+1-bit subtraction is exactly left < right.
  always_comb begin
    sum_ext  = {1'b0, left} + {1'b0, right};
    diff_ext = {1'b0, left} - {1'b0, right};
    alu_res  = '0;
    alu_flag = 1'b0;
    case (mode)
      2'd0: begin
        alu_res  = sum_ext;
        alu_flag = sum_ext[WIDTH];
      end
      2'd1: begin
        alu_res  = {1'b0, diff_ext[WIDTH-1:0]};
        alu_flag = diff_ext[WIDTH];
      end
      2'd2:    alu_res = (left >= right) ? {1'b0, left} : {1'b0, right};
      default: alu_res = {1'b0, left & right};
    endcase
  end

  always_comb begin
    wrap     = (presc_q == PRESC_MAX);
    presc_d  = wrap ? '0 : presc_q + 1'b1;
    digit_d  = wrap ? digit_q + 2'd1 : digit_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = valid_q;
    if (load) begin
      result_d = alu_res;
      flag_d   = alu_flag;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      presc_q  <= '0;
      digit_q  <= 2'd0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      presc_q  <= presc_d;
      digit_q  <= digit_d;
    end
  end

  assign result = result_q;
  assign flag   = flag_q;
  assign valid  = valid_q;

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    case (nib)
      4'h0: seg_enc = 7'b1000000;
      4'h1: seg_enc = 7'b1111001;
      4'h2: seg_enc = 7'b0100100;
      4'h3: seg_enc = 7'b0110000;
      4'h4: seg_enc = 7'b0011001;
      4'h5: seg_enc = 7'b0010010;
      4'h6: seg_enc = 7'b0000010;
      4'h7: seg_enc = 7'b1111000;
      4'h8: seg_enc = 7'b0000000;
      4'h9: seg_enc = 7'b0010000;
      4'hA: seg_enc = 7'b0001000;
      4'hB: seg_enc = 7'b0000011;
      4'hC: seg_enc = 7'b1000110;
      4'hD: seg_enc = 7'b0100001;
      4'hE: seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  logic [15:0] disp;
  logic [3:0]  nibble;
`ifdef ALU_SCAN7SEG_BLANK_EN
  logic [3:0]  lead_zero;
`endif

  // Display decodes only from registered state, never from the raw operands.
  always_comb begin
    disp          = '0;
    disp[WIDTH:0] = result_q;
    nibble        = disp[{digit_q, 2'b00} +: 4];
    g_to_a        = seg_enc(nibble);
    an            = ~(4'b0001 << digit_q);
    dp            = ~((digit_q == 2'd3) && flag_q);
`ifdef ALU_SCAN7SEG_BLANK_EN
    lead_zero[3] = (disp[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (disp[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (disp[7:4] == 4'h0);
    lead_zero[0] = 1'b0;
    if (lead_zero[digit_q]) begin
      g_to_a = 7'b1111111;
      // A pending carry/borrow keeps digit 3 lit as a bare decimal point.
      if ((digit_q == 2'd3) && flag_q) begin
        an = 4'b0111;
        dp = 1'b0;
      end else begin
        an = 4'b1111;
        dp = 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_scan7seg.sv
// Directed bench for alu_scan7seg (WIDTH=8, SCAN_DIV=4); scenario tasks with inline checks.
module tb_alu_scan7seg;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] left = '0;
  logic [WIDTH-1:0] right = '0;
  logic [1:0]       mode = '0;
  logic             load = 1'b0;
  logic [WIDTH:0]   result;
  logic             flag;
  logic             valid;
  logic [6:0]       g_to_a;
  logic [3:0]       an;
  logic             dp;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] seen;
  logic [6:0] slot_seg [4];
  logic       slot_dp  [4];
  int         blank_cnt;
  int         bad_an_cnt;

  alu_scan7seg #(.WIDTH(WIDTH), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .mode(mode), .load(load),
    .result(result), .flag(flag), .valid(valid), .g_to_a(g_to_a), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    left = a; right = b; mode = m; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // Records what each anode slot displays over n cycles.
  task automatic observe(input int n);
    seen = '0; blank_cnt = 0; bad_an_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      slot_seg[i] = 'x; slot_dp[i] = 1'bx;
    end
    for (int i = 0; i < n; i++) begin
      tick(1);
      case (an)
        4'b1110: begin seen[0] = 1'b1; slot_seg[0] = g_to_a; slot_dp[0] = dp; end
        4'b1101: begin seen[1] = 1'b1; slot_seg[1] = g_to_a; slot_dp[1] = dp; end
        4'b1011: begin seen[2] = 1'b1; slot_seg[2] = g_to_a; slot_dp[2] = dp; end
        4'b0111: begin seen[3] = 1'b1; slot_seg[3] = g_to_a; slot_dp[3] = dp; end
        4'b1111: begin blank_cnt++; if (dp !== 1'b1) bad_an_cnt++; end
        default: bad_an_cnt++;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an1;
`ifdef ALU_SCAN7SEG_BLANK_EN
    exp_an1 = 4'b1111;
`else
    exp_an1 = 4'b1101;
`endif
    rst = 1'b1; load = 1'b1; left = 8'hFF; right = 8'h01;
    tick(2);
    rst = 1'b0; load = 1'b0;
    total_cnt++; if (result !== 9'h000) $display("FAIL reset_result got %h exp 000", result); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else pass_cnt++;
    total_cnt++; if (flag !== 1'b0) $display("FAIL reset_flag got %b exp 0", flag); else pass_cnt++;
    total_cnt++; if (an !== 4'b1110) $display("FAIL reset_an got %b exp 1110", an); else pass_cnt++;
    total_cnt++; if (g_to_a !== 7'b1000000) $display("FAIL reset_seg got %b exp 1000000", g_to_a); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL reset_dp got %b exp 1", dp); else pass_cnt++;
    tick(3);
    total_cnt++; if (an !== 4'b1110) $display("FAIL reset_an_3cyc got %b exp 1110", an); else pass_cnt++;
    tick(1);
    total_cnt++; if (an !== exp_an1) $display("FAIL reset_an_4cyc got %b exp %b", an, exp_an1); else pass_cnt++;
    tick(12);
    total_cnt++; if (an !== 4'b1110) $display("FAIL reset_an_16cyc got %b exp 1110", an); else pass_cnt++;
  endtask

  task automatic test_add_carry();
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    exp_seg[0] = 7'b0000110; exp_seg[1] = 7'b0001110; exp_seg[2] = 7'b1111001;
`ifdef ALU_SCAN7SEG_BLANK_EN
    exp_seg[3] = 7'b1111111;
`else
    exp_seg[3] = 7'b1000000;
`endif
    exp_dp[0] = 1'b1; exp_dp[1] = 1'b1; exp_dp[2] = 1'b1; exp_dp[3] = 1'b0;
    do_load(8'hFF, 8'hFF, 2'd0);
    total_cnt++; if (result !== 9'h1FE) $display("FAIL add_result got %h exp 1fe", result); else pass_cnt++;
    total_cnt++; if (flag !== 1'b1) $display("FAIL add_flag got %b exp 1", flag); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1) $display("FAIL add_valid got %b exp 1", valid); else pass_cnt++;
    observe(16);
    total_cnt++; if (bad_an_cnt != 0) $display("FAIL add_an_legal got %0d bad exp 0", bad_an_cnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (seen[i] !== 1'b1 || slot_seg[i] !== exp_seg[i] || slot_dp[i] !== exp_dp[i])
        $display("FAIL add_digit%0d got seen=%b seg=%b dp=%b exp seen=1 seg=%b dp=%b",
                 i, seen[i], slot_seg[i], slot_dp[i], exp_seg[i], exp_dp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sub_borrow();
    do_load(8'h03, 8'h05, 2'd1);
    total_cnt++; if (result !== 9'h0FE) $display("FAIL sub_borrow_result got %h exp 0fe", result); else pass_cnt++;
    total_cnt++; if (flag !== 1'b1) $display("FAIL sub_borrow_flag got %b exp 1", flag); else pass_cnt++;
    do_load(8'h05, 8'h03, 2'd1);
    total_cnt++; if (result !== 9'h002) $display("FAIL sub_result got %h exp 002", result); else pass_cnt++;
    total_cnt++; if (flag !== 1'b0) $display("FAIL sub_flag got %b exp 0", flag); else pass_cnt++;
  endtask

  task automatic test_max_and_hold();
    do_load(8'hA5, 8'h3C, 2'd2);
    total_cnt++; if (result !== 9'h0A5) $display("FAIL max_left got %h exp 0a5", result); else pass_cnt++;
    do_load(8'h10, 8'h20, 2'd2);
    total_cnt++; if (result !== 9'h020) $display("FAIL max_right got %h exp 020", result); else pass_cnt++;
    do_load(8'hFF, 8'h01, 2'd0);
    do_load(8'hA5, 8'h3C, 2'd3);
    total_cnt++; if (result !== 9'h024) $display("FAIL and_result got %h exp 024", result); else pass_cnt++;
    total_cnt++; if (flag !== 1'b0) $display("FAIL and_flag got %b exp 0", flag); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      left  = 8'($urandom_range(0, 255));
      right = 8'($urandom_range(0, 255));
      mode  = 2'($urandom_range(0, 3));
      tick(1);
    end
    total_cnt++; if (result !== 9'h024) $display("FAIL hold_result got %h exp 024", result); else pass_cnt++;
    total_cnt++; if (flag !== 1'b0 || valid !== 1'b1)
      $display("FAIL hold_flag_valid got %b%b exp 01", flag, valid); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    total_cnt++; if (an !== 4'b1110 || result !== 9'h000)
      $display("FAIL pre_wrap got an=%b res=%h exp an=1110 res=000", an, result); else pass_cnt++;
    do_load(8'h12, 8'h34, 2'd0);
    total_cnt++; if (result !== 9'h046 || an !== 4'b1101)
      $display("FAIL load_wrap got an=%b res=%h exp an=1101 res=046", an, result); else pass_cnt++;
    total_cnt++; if (g_to_a !== 7'b0011001) $display("FAIL load_wrap_seg got %b exp 0011001", g_to_a); else pass_cnt++;
    left = 8'hFF; right = 8'hFF; mode = 2'd0; load = 1'b1; rst = 1'b1;
    tick(1);
    rst = 1'b0; load = 1'b0;
    total_cnt++; if (result !== 9'h000 || valid !== 1'b0 || flag !== 1'b0)
      $display("FAIL rst_load got res=%h v=%b f=%b exp 000 0 0", result, valid, flag); else pass_cnt++;
    total_cnt++; if (an !== 4'b1110) $display("FAIL rst_load_an got %b exp 1110", an); else pass_cnt++;
  endtask

`ifdef ALU_SCAN7SEG_BLANK_EN
  task automatic test_blanking();
    do_load(8'hA5, 8'h3C, 2'd3);
    observe(16);
    total_cnt++; if (seen[3] !== 1'b0 || seen[2] !== 1'b0)
      $display("FAIL blank_upper got seen=%b exp 0011", seen); else pass_cnt++;
    total_cnt++; if (blank_cnt == 0 || bad_an_cnt != 0)
      $display("FAIL blank_slots got blank=%0d bad=%0d exp >0 and 0", blank_cnt, bad_an_cnt); else pass_cnt++;
    total_cnt++; if (seen[0] !== 1'b1 || slot_seg[0] !== 7'b0011001)
      $display("FAIL blank_digit0 got %b exp 0011001", slot_seg[0]); else pass_cnt++;
    total_cnt++; if (seen[1] !== 1'b1 || slot_seg[1] !== 7'b0100100)
      $display("FAIL blank_digit1 got %b exp 0100100", slot_seg[1]); else pass_cnt++;
    do_load(8'h03, 8'h05, 2'd1);
    observe(16);
    total_cnt++; if (seen[3] !== 1'b1 || slot_seg[3] !== 7'b1111111 || slot_dp[3] !== 1'b0)
      $display("FAIL blank_flag_dp got seen=%b seg=%b dp=%b exp 1 1111111 0", seen[3], slot_seg[3], slot_dp[3]);
    else pass_cnt++;
    total_cnt++; if (seen[2] !== 1'b0) $display("FAIL blank_flag_d2 got seen=%b exp 0", seen[2]); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_max_and_hold();
    test_simultaneous();
`ifdef ALU_SCAN7SEG_BLANK_EN
    test_blanking();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
